// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU
// port (core_*) and a debug/loader port (ext_*).
//
// Ports
//   clk, reset (async, active low)
//   core_req/we/addr/wdata/mask  -> core_gnt, core_stall, core_rvalid, core_rdata
//   ext_req/we/addr/wdata/mask   -> ext_gnt, ext_rvalid, ext_rdata
//   mem_cs/rd_en/wr_en/addr/wdata/mask -> memory; mem_rdata valid one cycle after mem_rd_en
//
// Writes complete in the grant cycle. Reads take the grant cycle plus one
// response cycle (CORE_RD/EXT_RD), during which no new grant is issued.
// Core has priority by default.
//
// Optional feature macro: DMEM_ARB_FAIRNESS_EN. When defined, a saturating
// starvation counter forces an ext win after STARVE_LIMIT lost arbitrations.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_mask,
  output logic        core_gnt,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_mask,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_cs,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    EXT_RD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic [31:0] ext_rdata_q, ext_rdata_d;
  logic        core_win, ext_win, force_ext;

  // Grants are combinational from IDLE; gating with reset keeps every grant
  // low while reset is held.
  assign core_win = reset && (state_q == IDLE) && core_req && !(ext_req && force_ext);
  assign ext_win  = reset && (state_q == IDLE) && ext_req && !core_win;

`ifdef DMEM_ARB_FAIRNESS_EN
  logic [3:0] starve_q, starve_d;

  assign force_ext = (starve_q >= 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (ext_win)
        starve_d = '0;
      else if (ext_req && (starve_q != 4'hF))
        starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign force_ext = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    core_gnt     = 1'b0;
    ext_gnt      = 1'b0;
    mem_cs       = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mask     = '0;
    unique case (state_q)
      IDLE: begin
        if (core_win) begin
          core_gnt  = 1'b1;
          mem_cs    = 1'b1;
          mem_wr_en = core_we;
          mem_rd_en = !core_we;
          mem_addr  = core_addr;
          mem_wdata = core_wdata;
          mem_mask  = core_mask;
          if (!core_we) state_d = CORE_RD;
        end else if (ext_win) begin
          ext_gnt   = 1'b1;
          mem_cs    = 1'b1;
          mem_wr_en = ext_we;
          mem_rd_en = !ext_we;
          mem_addr  = ext_addr;
          mem_wdata = ext_wdata;
          mem_mask  = ext_mask;
          if (!ext_we) state_d = EXT_RD;
        end
      end
      CORE_RD: begin
        core_rdata_d = mem_rdata;
        state_d      = IDLE;
      end
      EXT_RD: begin
        ext_rdata_d = mem_rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The response cycle forwards mem_rdata directly so rvalid lands one cycle
  // after the grant; the captured copy holds the value afterwards.
  assign core_rvalid = (state_q == CORE_RD);
  assign ext_rvalid  = (state_q == EXT_RD);
  assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
  assign ext_rdata   = ext_rvalid  ? mem_rdata : ext_rdata_q;
  assign core_stall  = core_req && !(core_gnt && core_we) && !core_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        core_req, core_we, ext_req, ext_we;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic [3:0]  core_mask, ext_mask;
  logic        core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] core_rdata, ext_rdata;
  logic        mem_cs, mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_resp;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mask(core_mask),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_mask(ext_mask),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_cs(mem_cs), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after mem_rd_en.
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_resp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_mask = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_mask = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    mem_resp = '0;
    core_req = 1; ext_req = 1;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt got %b want 0", core_gnt); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_ext_gnt got %b want 0", ext_gnt); end
    checks++; if ({mem_cs, mem_rd_en, mem_wr_en} !== 3'b000) begin errors++; $display("FAIL reset_mem_ctl got %b want 000", {mem_cs, mem_rd_en, mem_wr_en}); end
    checks++; if ({core_rvalid, ext_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {core_rvalid, ext_rvalid}); end
    checks++; if (core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", core_rdata, ext_rdata); end
    step();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    checks++; if ({mem_cs, mem_addr, mem_wdata, mem_mask} !== 69'h0) begin errors++; $display("FAIL idle_mem_zero got cs=%b addr=%h", mem_cs, mem_addr); end
    step();
  endtask

  task automatic test_core_write();
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_mask = 4'hF;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL cw_gnt got %b want 1", core_gnt); end
    checks++; if ({mem_cs, mem_wr_en, mem_rd_en} !== 3'b110) begin errors++; $display("FAIL cw_mem_ctl got %b want 110", {mem_cs, mem_wr_en, mem_rd_en}); end
    checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || mem_mask !== 4'hF) begin errors++; $display("FAIL cw_mem_fields got %h %h %h want 10 deadbeef f", mem_addr, mem_wdata, mem_mask); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cw_stall got %b want 0", core_stall); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if ({mem_cs, mem_wr_en, mem_addr} !== 34'h0) begin errors++; $display("FAIL cw_after got cs=%b we=%b addr=%h want 0", mem_cs, mem_wr_en, mem_addr); end
    step();
  endtask

  task automatic test_core_read();
    mem_resp = 32'h12345678;
    core_req = 1; core_we = 0; core_addr = 32'h20; core_mask = 4'hF;
    @(negedge clk);
    checks++; if ({core_gnt, mem_rd_en, mem_wr_en, core_stall} !== 4'b1101) begin errors++; $display("FAIL cr_c0 got gnt/rd/wr/stall=%b want 1101", {core_gnt, mem_rd_en, mem_wr_en, core_stall}); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL cr_addr got %h want 20", mem_addr); end
    step();
    @(negedge clk);
    checks++; if ({core_rvalid, core_stall, core_gnt, mem_cs} !== 4'b1000) begin errors++; $display("FAIL cr_c1 got rv/stall/gnt/cs=%b want 1000", {core_rvalid, core_stall, core_gnt, mem_cs}); end
    checks++; if (core_rdata !== 32'h12345678) begin errors++; $display("FAIL cr_rdata got %h want 12345678", core_rdata); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h12345678) begin errors++; $display("FAIL cr_hold got rv=%b data=%h want 0 12345678", core_rvalid, core_rdata); end
    step();
  endtask

  task automatic test_ext_read();
    mem_resp = 32'hCAFEF00D;
    ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    @(negedge clk);
    checks++; if ({ext_gnt, core_gnt, mem_rd_en} !== 3'b101 || mem_addr !== 32'h44) begin errors++; $display("FAIL er_c0 got gnt/cgnt/rd=%b addr=%h want 101 44", {ext_gnt, core_gnt, mem_rd_en}, mem_addr); end
    step();
    ext_req = 0;
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL er_c1 got rv=%b data=%h want 1 cafef00d", ext_rvalid, ext_rdata); end
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h12345678) begin errors++; $display("FAIL er_core_untouched got rv=%b data=%h want 0 12345678", core_rvalid, core_rdata); end
    step();
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL er_hold got rv=%b data=%h want 0 cafef00d", ext_rvalid, ext_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      core_req = 1; core_we = 1; core_addr = 32'h100 + 32'(4 * i);
      core_wdata = 32'hA0 + 32'(i); core_mask = 4'(1 << i);
      @(negedge clk);
      checks++; if ({core_gnt, mem_wr_en} !== 2'b11 || mem_addr !== 32'h100 + 32'(4 * i) || mem_mask !== 4'(1 << i)) begin errors++; $display("FAIL b2b_%0d got gnt/we=%b addr=%h mask=%h", i, {core_gnt, mem_wr_en}, mem_addr, mem_mask); end
      step();
    end
    idle_inputs();
    ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h5A5A0001; ext_mask = 4'h3;
    @(negedge clk);
    checks++; if ({ext_gnt, mem_wr_en} !== 2'b11 || mem_wdata !== 32'h5A5A0001 || mem_mask !== 4'h3) begin errors++; $display("FAIL ext_write got gnt/we=%b wdata=%h mask=%h", {ext_gnt, mem_wr_en}, mem_wdata, mem_mask); end
    step();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_ext;
    do_reset();
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'h1;  core_mask = 4'hF;
    ext_req  = 1; ext_we  = 1; ext_addr  = 32'h90; ext_wdata  = 32'h2; ext_mask  = 4'hF;
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_FAIRNESS_EN
      exp_ext = ((i % 5) == 4);
`else
      exp_ext = 1'b0;
`endif
      @(negedge clk);
      checks++; if (ext_gnt !== exp_ext || core_gnt !== !exp_ext) begin errors++; $display("FAIL contend_cyc%0d got core/ext=%b%b want %b%b", i + 1, core_gnt, ext_gnt, !exp_ext, exp_ext); end
      checks++; if (mem_addr !== (exp_ext ? 32'h90 : 32'h10)) begin errors++; $display("FAIL contend_addr%0d got %h", i + 1, mem_addr); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_req_drop();
    mem_resp = 32'h0BADCAFE;
    core_req = 1; core_we = 0; core_addr = 32'h30;
    ext_req = 1; ext_we = 1; ext_addr = 32'h94; ext_wdata = 32'h77; ext_mask = 4'hF;
    @(negedge clk);
    checks++; if ({core_gnt, ext_gnt} !== 2'b10) begin errors++; $display("FAIL drop_c0 got core/ext=%b want 10", {core_gnt, ext_gnt}); end
    step();
    core_req = 0;
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h0BADCAFE) begin errors++; $display("FAIL drop_rvalid got rv=%b data=%h want 1 0badcafe", core_rvalid, core_rdata); end
    checks++; if ({ext_gnt, mem_cs} !== 2'b00) begin errors++; $display("FAIL drop_no_gnt got gnt/cs=%b want 00", {ext_gnt, mem_cs}); end
    step();
    @(negedge clk);
    checks++; if ({ext_gnt, mem_wr_en, core_rvalid} !== 3'b110 || mem_addr !== 32'h94) begin errors++; $display("FAIL drop_ext_next got gnt/we/rv=%b addr=%h want 110 94", {ext_gnt, mem_wr_en, core_rvalid}, mem_addr); end
    step();
    idle_inputs();
  endtask

  task automatic test_ext_read_reset();
    mem_resp = 32'hFEEDFACE;
    ext_req = 1; ext_we = 0; ext_addr = 32'h48;
    @(negedge clk);
    checks++; if ({ext_gnt, mem_rd_en} !== 2'b11) begin errors++; $display("FAIL err_c0 got gnt/rd=%b want 11", {ext_gnt, mem_rd_en}); end
    step();
    reset = 0;
    #2;
    checks++; if ({ext_rvalid, core_rvalid, ext_gnt, core_gnt, mem_cs, mem_rd_en, mem_wr_en} !== 7'b0) begin errors++; $display("FAIL err_in_reset got %b want 0", {ext_rvalid, core_rvalid, ext_gnt, core_gnt, mem_cs, mem_rd_en, mem_wr_en}); end
    checks++; if (ext_rdata !== 32'h0 || core_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata got %h/%h want 0/0", ext_rdata, core_rdata); end
    #1;
    reset = 1;
    ext_req = 0;
    core_req = 1; core_we = 1; core_addr = 32'h60; core_wdata = 32'h99; core_mask = 4'hF;
    @(negedge clk);
    checks++; if ({core_gnt, mem_wr_en, ext_rvalid} !== 3'b110 || mem_addr !== 32'h60) begin errors++; $display("FAIL err_after got gnt/we/rv=%b addr=%h want 110 60", {core_gnt, mem_wr_en, ext_rvalid}, mem_addr); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL err_no_late_rvalid got %b want 0", ext_rvalid); end
    step();
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_core_read();
    test_ext_read();
    test_back_to_back();
    test_contention();
    test_req_drop();
    test_ext_read_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations before the ext port is forced; legal range 1-15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have core port inputs core_req 1, core_we 1, core_addr 32, core_wdata 32, core_mask 4: the LSU data-memory request.
REQ-005 SHALL have core port outputs core_gnt 1, core_stall 1, core_rvalid 1, core_rdata 32.
REQ-006 SHALL have ext port inputs ext_req 1, ext_we 1, ext_addr 32, ext_wdata 32, ext_mask 4: the debug/loader request.
REQ-007 SHALL have ext port outputs ext_gnt 1, ext_rvalid 1, ext_rdata 32.
REQ-008 SHALL have memory outputs mem_cs 1, mem_rd_en 1, mem_wr_en 1, mem_addr 32, mem_wdata 32, mem_mask 4, and memory input mem_rdata 32, valid one cycle after mem_rd_en.

Function
REQ-009 SHALL implement FSM states IDLE, CORE_RD, EXT_RD.
REQ-010 In IDLE with any request, SHALL grant exactly one port that cycle: assert its gnt and drive mem_cs plus that port's addr/wdata/mask combinationally.
REQ-011 Granted write SHALL assert mem_wr_en for that one cycle and stay in IDLE; back-to-back writes at one per cycle.
REQ-012 Granted read SHALL assert mem_rd_en for one cycle and move to CORE_RD or EXT_RD.
REQ-013 In CORE_RD/EXT_RD, SHALL register mem_rdata into the owner's rdata, pulse its rvalid one cycle later, return to IDLE, and issue no memory command; read throughput is one per two cycles.
REQ-014 Default priority: core wins when both request.
REQ-015 core_stall SHALL equal core_req AND NOT (core_gnt AND core_we) AND NOT core_rvalid.
REQ-016 A port's request fields SHALL be ignored when not granted; requesters hold req and fields until gnt; a req drop after gnt SHALL NOT cancel the pending rvalid.
REQ-017 rdata outputs SHALL hold their last value between rvalid pulses.
REQ-018 mem_* outputs SHALL be 0 whenever mem_cs is 0.
REQ-019 No gnt SHALL be asserted while in CORE_RD or EXT_RD.

Reset
REQ-020 While reset is low, SHALL hold state IDLE, starvation counter 0, all gnt, rvalid, mem_cs, mem_rd_en and mem_wr_en at 0, and all rdata at 0.
REQ-021 Reset during CORE_RD/EXT_RD SHALL drop the pending read; no rvalid is issued for it.

Configuration
REQ-022 With DMEM_ARB_FAIRNESS_EN defined, a saturating 4-bit counter SHALL increment each IDLE cycle in which ext_req is high and ext loses, and clear on ext_gnt.
REQ-023 With DMEM_ARB_FAIRNESS_EN defined and the counter at STARVE_LIMIT or more, ext SHALL win the next contended IDLE arbitration.
REQ-024 Without DMEM_ARB_FAIRNESS_EN, SHALL use strict core priority with no counter logic.

Verification
REQ-025 Core write only: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, mask=0xF -> same cycle core_gnt=1, mem_wr_en=1, mem_addr=0x10, core_stall=0.
REQ-026 Core read: addr=0x20, memory returns 0x12345678 -> cycle 0 gnt+mem_rd_en with stall=1; cycle 1 core_rvalid=1, core_rdata=0x12345678, stall=0; back in IDLE.
REQ-027 Contention, macro off: core and ext both write continuously for 10 cycles -> core_gnt every cycle, ext_gnt never.
REQ-028 Contention, macro on, STARVE_LIMIT=4: core and ext both write continuously -> ext_gnt on cycle 5, then on every 5th cycle; counter 0 after each ext grant.
REQ-029 Ext read issued, reset pulsed low during EXT_RD -> no ext_rvalid, all outputs 0; after release, a core write is granted in the first cycle.
REQ-030 Core read granted, then core_req dropped next cycle while ext_req=1 -> core_rvalid still pulses with data, ext_gnt not asserted in that cycle, ext granted in the following IDLE cycle.
